// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Package  : if_pkg
// Purpose  : Shared types, constants and helpers for the instruction-fetch
//            stage (instr_fetch) and its FIFO (fetch_queue).
// Contents : INSTR_W        - instruction word width
//            RESET_PC_DEF   - default fetch address after reset
//            fetch_entry_t  - {pc, instr, pcplus4} record handed to decode
//            ENTRY_W        - packed width of fetch_entry_t
//            pc_inc()       - sequential PC step (+4, wraps modulo 2^32)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One decoded-stage record. pcplus4 travels with the word so next-PC
  // selection never has to recompute it.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pcplus4;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Sequential PC step; natural 32-bit overflow gives the FFFF_FFFC -> 0 wrap.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Small synchronous FIFO with registered storage, synchronous
//            flush and an occupancy count. Head is shown combinationally
//            from storage; a push is visible at the head one cycle later.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - empties the FIFO (wins over push and pop)
//            push, push_data - write request (ignored when full, unless a
//                              pop frees a slot in the same cycle)
//            pop             - remove head (ignored when empty)
//            head            - current head entry (undefined when empty)
//            count           - entries held, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  // A single-entry FIFO still needs a 1-bit pointer to index storage.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Architectural fetch PC and instruction-fetch stage. Issues
//            in-order word requests to instruction memory under a credit
//            limit of DEPTH (outstanding requests + buffered words), pairs
//            each returned word with its PC and PC+4, and presents them to
//            decode. A redirect restarts fetch at a new PC, flushes buffered
//            words and discards responses still in flight.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            redirect, redirect_pc      - taken-control-flow restart
//            imem_req_valid/ready/addr  - memory request handshake
//            imem_resp_valid/data       - in-order memory responses
//            if_valid/ready             - decode handshake
//            if_instr/if_pc/if_pcplus4  - head record for decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pcplus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]        pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      outstanding_nxt;
  logic [CW-1:0]      drop_cnt;
  logic [CW:0]        credit_used;
  logic               req_fire;
  logic               resp_fire;
  logic               resp_keep;

  logic [31:0]        aq_head;
  logic [CW-1:0]      aq_count;
  logic [CW-1:0]      oq_count;
  logic [ENTRY_W-1:0] oq_head_bits;
  logic [ENTRY_W-1:0] oq_push_bits;
  fetch_entry_t       oq_head;
  fetch_entry_t       oq_push;
  logic               oq_pop;

  // Target alignment bits are architecturally ignored.
  logic               unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // --------------------------------------------------------------------------
  // Request side. Credit counts words we may still have to buffer: every
  // outstanding request (including ones to be dropped) plus every buffered
  // word. The request depends only on registered state and redirect, never
  // on the memory response, so there is no memory->request combinational path.
  // --------------------------------------------------------------------------
  assign credit_used    = {1'b0, outstanding} + {1'b0, oq_count};
  assign imem_req_valid = rst_n && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and ignored.
  assign resp_fire      = imem_resp_valid && (outstanding != '0);
  // Words owed to a pre-redirect stream, or arriving in the redirect cycle,
  // belong to the old path and are discarded.
  assign resp_keep      = resp_fire && (drop_cnt == '0) && !redirect;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle is old-path traffic.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) pc <= pc_inc(pc);
        if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // In-flight address queue: remembers the PC of each accepted request so
  // the in-order response can be tagged. Never flushed; dropped responses
  // still pop their address.
  // --------------------------------------------------------------------------
  fetch_queue #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_fire),
    .head      (aq_head),
    .count     (aq_count)
  );

  // --------------------------------------------------------------------------
  // Output queue toward decode. Redirect flushes it, overriding a pop.
  // --------------------------------------------------------------------------
  always_comb begin
    oq_push         = '0;
    oq_push.pc      = aq_head;
    oq_push.instr   = imem_resp_data;
    oq_push.pcplus4 = pc_inc(aq_head);
  end

  assign oq_push_bits = oq_push;
  assign oq_head      = oq_head_bits;
  assign oq_pop       = if_valid && if_ready && !redirect;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_out_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (oq_push_bits),
    .pop       (oq_pop),
    .head      (oq_head_bits),
    .count     (oq_count)
  );

  // Fields read as zero whenever nothing is presented (including reset).
  assign if_valid   = (oq_count != '0);
  assign if_instr   = if_valid ? oq_head.instr   : '0;
  assign if_pc      = if_valid ? oq_head.pc      : '0;
  assign if_pcplus4 = if_valid ? oq_head.pcplus4 : '0;

  // --------------------------------------------------------------------------
  // Checks
  // --------------------------------------------------------------------------
  a_resp_needs_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding != '0)
  );

  a_addr_q_tracks_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    aq_count == outstanding
  );

  // Once offered, a request is held with a stable address until accepted,
  // except that a redirect may withdraw it.
  a_req_held_until_accept : assert property (
    @(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready) |=>
      (redirect || (imem_req_valid && $stable(imem_addr)))
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch (DEPTH=2,
//            RESET_PC=0x100). A memory model answers accepted requests one
//            cycle later in order; a scoreboard keeps the expected fetch PC
//            stream and compares every word handed to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;

  logic        resp_en;
  logic [31:0] pend[$];     // requests accepted by the memory model
  logic [31:0] exp_out[$];  // scoreboard: PCs expected at decode, in order
  logic [31:0] epc;         // next expected request address
  int          acc_cnt;
  int          n_checks;
  int          n_pass;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pcplus4      (if_pcplus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ~a ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory: one response per cycle, in order, driven 2 time units after the
  // edge so it sees stimulus applied 1 unit after the same edge.
  always @(posedge clk) begin
    logic [31:0] a;
    #2;
    imem_resp_valid = 1'b0;
    if (!rst_n) begin
      pend.delete();
    end else if (resp_en && pend.size() > 0) begin
      a = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(a);
    end
  end

  // Monitor: sample on the falling edge, check requests and decode outputs.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, epc);
        pend.push_back(imem_addr);
        exp_out.push_back(epc);
        epc = epc + 32'd4;
        acc_cnt++;
      end
      // In a redirect cycle the head is flushed, not consumed.
      if (if_valid && if_ready && !redirect) begin
        e = (exp_out.size() > 0) ? exp_out.pop_front() : 32'hDEAD_BEEF;
        chk("out_pc", if_pc, e);
        chk("out_instr", if_instr, memf(e));
        chk("out_pcplus4", if_pcplus4, e + 32'd4);
      end
    end
  end

  task automatic do_reset(input logic redir, input logic [31:0] tgt);
    rst_n    = 1'b0;
    redirect = 1'b0;
    exp_out.delete();
    epc      = redir ? {tgt[31:2], 2'b00} : RST_PC;
    acc_cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    redirect    = redir;
    redirect_pc = tgt;
    if (redir) begin
      @(posedge clk);
      #1;
      redirect = 1'b0;
    end
  endtask

  task automatic wait_out(input logic [31:0] want, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_valid && if_pc == want) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; acc_cnt = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1; resp_en = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = '0; epc = RST_PC;

    // ---- reset state ----
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid",  {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr",  if_instr, 32'd0);
    chk("rst_if_pc",     if_pc, 32'd0);
    chk("rst_if_pcplus4", if_pcplus4, 32'd0);

    // ---- T1: sequential fetch and first-word latency ----
    do_reset(1'b0, '0);
    @(negedge clk);
    chk("t1_first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_first_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("t1_valid_n1", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", {31'b0, if_valid}, 32'd1);
    chk("t1_pc_n2", if_pc, 32'h100);
    chk("t1_pcplus4_n2", if_pcplus4, 32'h104);
    repeat (12) @(negedge clk);

    // ---- T2: decode stall, credit limit, head stability ----
    if_ready = 1'b0;
    do_reset(1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) chk("t2_head_held", if_valid ? if_pc : 32'hFFFF_FFFF, 32'h100);
    end
    chk("t2_accept_count", acc_cnt, 32'd2);
    chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    step();
    if_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_still_blocked", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("t2_req_resumed", {31'b0, imem_req_valid}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h108);
    repeat (6) @(negedge clk);

    // ---- T3: redirect with two requests outstanding ----
    resp_en = 1'b0;
    do_reset(1'b1, 32'h200);
    @(negedge clk);
    chk("t3_addr0", imem_addr, 32'h200);
    step();
    @(negedge clk);
    chk("t3_addr1", imem_addr, 32'h204);
    step();
    redirect = 1'b1; redirect_pc = 32'h1003;
    exp_out.delete(); epc = 32'h1000;
    @(negedge clk);
    chk("t3_req_low_in_R", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    chk("t3_drop_holds_credit", {31'b0, imem_req_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("t3_req_after_drop", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_new_addr", imem_addr, 32'h1000);
    wait_out(32'h1000, "t3_first_out");

    // ---- T4: redirect coincides with a response and a decode pop ----
    if_ready = 1'b1; resp_en = 1'b1;
    do_reset(1'b1, 32'h2FC);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t4_addr_300", imem_addr, 32'h300);
    step();
    redirect = 1'b1; redirect_pc = 32'h400;
    exp_out.delete(); epc = 32'h400;
    @(negedge clk);
    chk("t4_head_in_R", if_pc, 32'h2FC);
    chk("t4_resp_in_R", {31'b0, imem_resp_valid}, 32'd1);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_flushed", {31'b0, if_valid}, 32'd0);
    chk("t4_req_R1", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_addr_R1", imem_addr, 32'h400);
    step();
    @(negedge clk);
    chk("t4_req_R2", {31'b0, imem_req_valid}, 32'd1);
    wait_out(32'h400, "t4_first_out");

    // ---- T5: PC wrap at the top of the address space ----
    do_reset(1'b1, 32'hFFFF_FFF8);
    wait_out(32'hFFFF_FFFC, "t5_top_word");
    chk("t5_pcplus4_wrap", if_pcplus4, 32'd0);
    wait_out(32'h0, "t5_wrapped_word");
    chk("t5_pcplus4_zero", if_pcplus4, 32'd4);

    // ---- T6: asynchronous reset mid-fetch ----
    if_ready = 1'b0; resp_en = 1'b1;
    do_reset(1'b0, '0);
    repeat (4) @(negedge clk);
    chk("t6_pre_valid", {31'b0, if_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_if_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_async_if_pc", if_pc, 32'd0);
    chk("t6_async_if_instr", if_instr, 32'd0);
    chk("t6_async_pcplus4", if_pcplus4, 32'd0);
    if_ready = 1'b1; resp_en = 1'b0;
    do_reset(1'b0, '0);
    @(negedge clk);
    chk("t6_restart_addr", imem_addr, RST_PC);
    repeat (2) @(negedge clk);
    chk("t6_two_outstanding", acc_cnt, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_async_req", {31'b0, imem_req_valid}, 32'd0);
    resp_en = 1'b1;
    do_reset(1'b0, '0);
    wait_out(RST_PC, "t6b_first_out");
    chk("t6b_instr", if_instr, memf(RST_PC));
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC register and instruction-fetch stage feeding decode.
- Holds the architectural fetch PC and issues in-order requests to instruction memory via a valid/ready handshake.
- Buffers returned words with their PC and PC+4 for decode; PC+4 travels down the pipe and is the sequential input to next-PC selection.
- Taken branch/jump/jr results from next-PC selection arrive as a redirect that flushes the stage and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, max outstanding memory requests plus buffered words (must be >= 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- redirect  in  1  single-cycle pulse; taken branch/jump/jal/jr.
- redirect_pc  in  32  target from next-PC selection; bits[1:0] ignored (treated 00).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response word valid; in request order, >= 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  32  instruction.
- if_pc  out  32  its address.
- if_pcplus4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC; outstanding = 0; drop_cnt = 0; queue empty.
  - imem_req_valid = 0, if_valid = 0; if_instr/if_pc/if_pcplus4 = 0.
- Issue:
  - imem_req_valid = !redirect && (outstanding + queue_count < DEPTH); imem_addr = pc.
  - On valid&ready: pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++, pc pushed to in-flight address queue.
  - Back-to-back issue every cycle while credit allows. No combinational path from memory to request.
- Response:
  - On imem_resp_valid, outstanding-- and the in-flight address queue is popped.
  - If drop_cnt > 0: word discarded, drop_cnt--.
  - Else: {pc, data, pc+4} pushed to output queue. Credit rule guarantees the queue is never full here.
  - Response with outstanding == 0 is a protocol error: ignored, SVA assertion fires.
- Output:
  - if_valid = queue non-empty; fields show the head entry.
  - Pop on if_valid & if_ready. Head stable while if_valid & !if_ready.
  - Latency: request accepted in cycle N with response in N+1 gives if_valid in N+2 (registered queue).
- Redirect (cycle R):
  - pc <= {redirect_pc[31:2],2'b00}; output queue flushed, including any pop in R (flush wins).
  - drop_cnt <= outstanding after R's request/response updates. A response arriving in R counts as pre-redirect and is dropped; a request accepted in R cannot occur (valid forced low).
  - imem_req_valid resumes in R+1 at the new pc, subject to credit (drop pending still consumes credit).
  - Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
- Memory contract: request may be withdrawn only on redirect; otherwise imem_addr is stable while valid & !ready.
- All counters are $clog2(DEPTH+1) bits wide; no overflow is reachable.

Decomposition:
- Package if_pkg:
  - fetch_entry_t struct {pc, instr, pcplus4}.
  - RESET_PC default, INSTR_W = 32.
  - Function pc_inc(pc) returning pc + 4.
- Sub-module fetch_queue: parameterised sync FIFO (DEPTH entries, flush input, count output).
  - Instantiated twice: output queue of fetch_entry_t; in-flight address queue of 32-bit.

Test Plan:
- Reset RESET_PC=32'h0000_0100, memory ready always, 1-cycle response, if_ready=1 -> addrs 0x100, 0x104, 0x108 consecutive; first if_valid 2 cycles after first accept with if_pc=0x100, if_pcplus4=0x104.
- if_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0; head held stable; releasing if_ready restores issue next cycle.
- Two requests outstanding (0x200, 0x204), redirect with redirect_pc=0x1003 -> both responses dropped; next request addr 0x1000; first if_pc after redirect 0x1000.
- Redirect coinciding with response for 0x300 and an if pop -> response dropped, queue empty in R+1, drop_cnt equals remaining outstanding.
- pc=0xFFFF_FFFC fetched -> if_pcplus4=0, next imem_addr=0.
- rst_n low mid-fetch with 2 outstanding -> outputs zero immediately (async); after release fetch restarts at RESET_PC; stale responses excluded by bench.
